// File: rtl/mcu_debug_responder.sv
// mcu_debug_responder
//   MCU-side executor for debug controller commands. A single request is
//   accepted in IDLE and run against the core halt/reset controls, the
//   register-file debug port or the memory debug port. Progress is reported
//   on mcu_busy and read data is returned on d_out.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   in_valid + request bits  one-hot command strobe (pause, mcu_reset, resume,
//                            rf_rd, rf_wr, mem_rd, mem_wr), addr / d_in operands
//   mcu_busy, d_out, err     status back to the controller
//   core_halt, core_idle,    core pipeline control
//   core_rst
//   rf_*                     register-file debug port (rdata combinational)
//   mem_*                    memory debug port (request held until mem_ack)
module mcu_debug_responder #(
  parameter int RST_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        pause,
  input  logic        mcu_reset,
  input  logic        resume,
  input  logic        rf_rd,
  input  logic        rf_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic        mcu_busy,
  output logic [31:0] d_out,
  output logic        err,
  output logic        core_halt,
  input  logic        core_idle,
  output logic        core_rst,
  output logic [4:0]  rf_addr,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_RST, S_RF, S_MEM, S_DONE} state_t;

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic        paused;
  logic        op_wr;     // write flavour of the accepted rf/mem request
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [7:0]  tcnt;
  logic [3:0]  rcnt;

  logic any_req, accept;
  assign any_req = pause | mcu_reset | resume | rf_rd | rf_wr | mem_rd | mem_wr;
  assign accept  = in_valid & (state == S_IDLE) & any_req;

  assign mcu_busy  = accept | (state != S_IDLE);
  assign core_halt = paused;

  // Port address/data only reflect the latched operands while that port is in
  // use, so rejected or unrelated requests leave both ports quiet.
  assign rf_addr   = (state == S_RF)  ? lat_addr[4:0] : 5'd0;
  assign rf_wdata  = (state == S_RF)  ? lat_data      : 32'd0;
  assign mem_addr  = (state == S_MEM) ? lat_addr      : 32'd0;
  assign mem_wdata = (state == S_MEM) ? lat_data      : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      paused   <= 1'b0;
      op_wr    <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      tcnt     <= '0;
      rcnt     <= '0;
      d_out    <= '0;
      err      <= 1'b0;
      core_rst <= 1'b0;
      rf_we    <= 1'b0;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          lat_addr <= addr;
          lat_data <= d_in;
          // Priority: mcu_reset > pause > resume > mem_wr > mem_rd > rf_wr > rf_rd
          if (mcu_reset) begin
            core_rst <= 1'b1;
            rcnt     <= RST_LAST;
            state    <= S_RST;
          end else if (pause) begin
            paused <= 1'b1;
            state  <= paused ? S_DONE : S_DRAIN;
          end else if (resume) begin
            paused <= 1'b0;
            state  <= S_DONE;
          end else if (mem_wr | mem_rd) begin
            op_wr <= mem_wr;
            if (!paused || addr[1:0] != 2'b00) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              mem_we <= mem_wr;
              mem_re <= ~mem_wr;
              tcnt   <= '0;
              state  <= S_MEM;
            end
          end else begin
            op_wr <= rf_wr;
            if (!paused) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              // x0 is hardwired: the write completes but never strobes
              rf_we <= rf_wr & (addr[4:0] != 5'd0);
              state <= S_RF;
            end
          end
        end
        S_DRAIN: if (core_idle) state <= S_DONE;
        S_RST: begin
          if (rcnt == 4'd0) begin
            core_rst <= 1'b0;
            state    <= S_DONE;
          end else begin
            rcnt <= rcnt - 4'd1;
          end
        end
        S_RF: begin
          rf_we <= 1'b0;
          if (!op_wr) d_out <= rf_rdata;
          state <= S_DONE;
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (!op_wr) d_out <= mem_rdata;
            state <= S_DONE;
          end else if (tcnt == TO_LAST) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            err    <= 1'b1;
            state  <= S_DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mcu_debug_responder.md
Name: mcu_debug_responder

Overview:
- MCU-side responder for the debug controller's command interface.
- Accepts one-hot debug requests (pause, reset, resume, rf_rd, rf_wr, mem_rd, mem_wr) qualified by in_valid.
- Executes each request against the core's halt/reset controls, register-file debug port and memory debug port.
- Reports progress to the controller with mcu_busy, and returns read data on d_out.

Parameters:
- RST_CYCLES, 4: number of cycles core_rst is held high per reset request (1..15).
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ack before aborting with error (1..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request strobe from controller
- pause  input  1  halt core request
- mcu_reset  input  1  core reset request
- resume  input  1  release halt request
- rf_rd  input  1  register-file read request
- rf_wr  input  1  register-file write request
- mem_rd  input  1  memory word read request
- mem_wr  input  1  memory word write request
- addr  input  32  register index (addr[4:0]) or byte address
- d_in  input  32  write data
- mcu_busy  output  1  request in progress
- d_out  output  32  last read data
- err  output  1  one-cycle pulse when a request is rejected or aborted
- core_halt  output  1  stall core fetch/issue
- core_idle  input  1  core pipeline drained
- core_rst  output  1  core reset (PC to 0)
- rf_addr  output  5  RF debug port address
- rf_we  output  1  RF debug write enable
- rf_wdata  output  32  RF debug write data
- rf_rdata  input  32  RF debug read data (combinational)
- mem_addr  output  32  memory debug address
- mem_re  output  1  memory debug read request
- mem_we  output  1  memory debug write request
- mem_wdata  output  32  memory debug write data
- mem_rdata  input  32  memory read data, valid with mem_ack
- mem_ack  input  1  memory access complete

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; paused flag 0; latched addr and data 0; timeout counter 0.
- Accept condition:
  - accept = in_valid & state==IDLE & any request bit set.
  - addr and d_in are latched on the accepting edge.
  - in_valid is ignored in any state other than IDLE.
- mcu_busy = accept | (state != IDLE), i.e. combinational, so it goes high in the same cycle as in_valid.
- Multiple request bits set at once: exactly one is executed, by priority mcu_reset > pause > resume > mem_wr > mem_rd > rf_wr > rf_rd.
- States: IDLE, DRAIN, RST, RF, MEM, DONE.
- pause:
  - Sets paused, so core_halt = 1 from the next cycle.
  - Goes to DRAIN, which holds until core_idle=1, then goes to DONE.
  - If already paused, goes straight to DONE.
- resume:
  - Clears paused, so core_halt drops the next cycle.
  - Goes to DONE; a resume while not paused is a no-op.
- mcu_reset:
  - Goes to RST, driving core_rst=1 for exactly RST_CYCLES cycles, then goes to DONE.
  - The paused flag is unchanged: a paused core stays halted after reset.
- rf_rd / rf_wr:
  - Legal only when paused. Otherwise pulse err and go to DONE with no side effects.
  - In RF (one cycle), rf_addr = latched addr[4:0].
  - Write: rf_we=1 and rf_wdata = latched data. A write to index 0 suppresses rf_we but still completes normally.
  - Read: d_out <= rf_rdata at the end of the RF cycle.
- mem_rd / mem_wr:
  - Legal only when paused and latched addr[1:0]==0. Otherwise pulse err and go to DONE.
  - In MEM, mem_addr is the latched addr, and mem_re or mem_we is held high until mem_ack.
  - On the edge where mem_ack=1: reads capture d_out <= mem_rdata, and the state goes to DONE.
  - After MEM_TIMEOUT cycles with no ack: deassert the request, pulse err, go to DONE, leave d_out unchanged.
  - mem_ack outside MEM is ignored.
- DONE: one cycle, mcu_busy=1, then back to IDLE. Every request therefore ends with at least one busy cycle after acceptance.
- d_out holds its value until the next successful read; writes and control requests do not alter it.
- Synchronous reset mid-operation:
  - Aborts immediately: all strobes drop on the next edge, paused clears, and no err pulse is generated.
  - A memory access already issued is abandoned.

Test Plan:
- pause with in_valid for 1 cycle, core_idle rising 3 cycles later -> mcu_busy high in the accept cycle, through DRAIN, and 1 DONE cycle; core_halt=1 from the next cycle and stays 1 after busy drops.
- mem_wr addr=0x10, d_in=0xCAFEF00D while paused, mem_ack after 2 cycles -> mem_we=1 for 2 cycles with mem_addr=0x10 and mem_wdata=0xCAFEF00D; then mem_rd with mem_rdata=0xCAFEF00D -> d_out=0xCAFEF00D, err never asserted.
- rf_rd addr=5 with the core not paused -> err pulses once, rf port untouched, mcu_busy high for exactly 2 cycles; rf_wr addr=0 while paused -> rf_we stays 0, no err.
- mem_rd addr=0x13 (misaligned) -> err pulse and no mem_re; mem_rd addr=0x20 with no mem_ack -> mem_re high for exactly MEM_TIMEOUT=16 cycles, then err, d_out unchanged.
- pause and resume both set with one in_valid while running -> only pause executes; then mcu_reset -> core_rst high exactly 4 cycles, core_halt still 1; then resume -> core_halt 0.
- reset asserted during a MEM wait -> next cycle mem_re=0, mcu_busy=0, core_halt=0, err=0, d_out=0.
